pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the five-stage integer core. Collects stall requests from IF, ID, EX and MEM and drives the per-stage hold vector consumed by the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Accepts precise exceptions from MEM through a valid/ack handshake and issues a one-cycle pipeline flush with the redirect PC. Also provides a stall watchdog and saturating performance counters.

## Interface
- WDOG_LIMIT, 1024: consecutive stalled cycles that set `wdog_err`; legal range 1..65535.
- clk  input  1  core clock.
- rst  input  1  asynchronous reset, active-low.
- stallreq_if  input  1  instruction fetch not ready.
- stallreq_id  input  1  load-use hazard in decode.
- stallreq_ex  input  1  multi-cycle EX operation (mul/div) busy.
- stallreq_mem  input  1  data memory not ready.
- excp_valid  input  1  exception pending at MEM; held until `excp_ack`.
- excp_vector  input  32  handler address; stable while `excp_valid`=1.
- stall  output  6  hold vector: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB.
- flush  output  1  clear all pipeline registers and load `new_pc`.
- new_pc  output  32  redirect PC, valid when `flush`=1.
- excp_ack  output  1  exception accepted, one-cycle pulse.
- wdog_err  output  1  sticky watchdog flag.
- stall_cnt  output  32  saturating count of cycles with `stall[0]`=1.
- flush_cnt  output  16  saturating count of flushes.

## Operation
- FSM states: RUN, ACCEPT, FLUSH. Reset state RUN.
- RUN, `stall` is combinational. The highest requesting stage wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 6'b000000
- RUN with `excp_valid`=1 and `stallreq_mem`=0: latch `excp_vector` and go to ACCEPT.
- RUN with `excp_valid`=1 and `stallreq_mem`=1: stay in RUN and apply the normal mem stall. The exception waits.
- ACCEPT (1 cycle):
  - `stall`=6'b111111 regardless of requests.
  - `excp_ack`=1.
  - Next state FLUSH.
- FLUSH (1 cycle):
  - `flush`=1, `new_pc`=latched vector, `stall`=0.
  - All requests are ignored.
  - `excp_valid` is not sampled.
  - `flush_cnt` increments.
  - Next state RUN.
- `new_pc` holds its last value outside FLUSH.
- Watchdog:
  - A 16-bit counter increments each cycle in which `stall`!=0.
  - It clears on any cycle with `stall`=0.
  - When it reaches WDOG_LIMIT, `wdog_err` goes to 1 and stays there until reset. The counter then saturates.
- Counters stop at all-ones and never wrap.

## Timing
- Reset (`rst`=0, asynchronous) forces every output to zero, including `new_pc`, and the state to RUN.
- The reset-induced zero of `stall`, `flush` and `excp_ack` is combinational with `rst`.
- Requests to `stall`: zero latency in RUN.
- Exception timing: `excp_valid` sampled at edge N (RUN, no mem stall) gives ACCEPT in cycle N+1 and FLUSH in cycle N+2. `excp_ack` is high in cycle N+1.
- The requester drops `excp_valid` after the edge ending cycle N+1.
- A new exception can be accepted at the earliest in cycle N+3.
- `stall_cnt` and `flush_cnt` update on the clock edge ending the counted cycle.
- Reset asserted in ACCEPT or FLUSH aborts the sequence: no flush is issued and no ack is given later.

## Structure
- Shared `defines` package:
  - ZeroWord.
  - InstAddrBus width.
  - Stall encodings: STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM, STALL_ALL.
  - FSM state constants.
- Single module, no sub-modules.
- The watchdog and the saturating counters are inline always blocks.

## Test plan
- Reset, then no requests: `stall`=0, `flush`=0, `new_pc`=0, counters 0.
- Simultaneous `stallreq_id`=1 and `stallreq_ex`=1 for 3 cycles: `stall`=6'b001111 for 3 cycles; `stall_cnt`=3.
- `excp_valid`=1 with vector 32'h0000_0380 and no stall:
  - next cycle `excp_ack`=1, `stall`=6'b111111;
  - following cycle `flush`=1, `new_pc`=32'h0000_0380;
  - `flush_cnt`=1.
- `excp_valid`=1 while `stallreq_mem`=1 for 4 cycles: no ack during those cycles and `stall`=6'b011111; ack arrives 1 cycle after `stallreq_mem` drops.
- WDOG_LIMIT=8 with `stallreq_ex` held 8 cycles: `wdog_err` rises after the 8th stalled cycle and stays 1 after the requests clear.
- `rst` pulsed low during ACCEPT: outputs go to 0 immediately, and no `flush` follows.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants and FSM state type for the pipeline controller
package pipe_ctrl_pkg;

  localparam int InstAddrBus = 32;
  localparam logic [InstAddrBus-1:0] ZeroWord = '0;

  // Hold vector bit order: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_ALL  = 6'b111111;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall arbitration, exception flush sequencing, watchdog and perf counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallreq_if,
  input  logic                   stallreq_id,
  input  logic                   stallreq_ex,
  input  logic                   stallreq_mem,
  input  logic                   excp_valid,
  input  logic [InstAddrBus-1:0] excp_vector,
  output logic [5:0]             stall,
  output logic                   flush,
  output logic [InstAddrBus-1:0] new_pc,
  output logic                   excp_ack,
  output logic                   wdog_err,
  output logic [31:0]            stall_cnt,
  output logic [15:0]            flush_cnt
);

  localparam logic [15:0] WDOG_LIM16 = 16'(WDOG_LIMIT);

  state_e                 state_q, state_d;
  logic [InstAddrBus-1:0] vec_q, vec_d;
  logic [InstAddrBus-1:0] new_pc_q, new_pc_d;
  logic [15:0]            wdog_cnt_q, wdog_cnt_d;
  logic                   wdog_err_q, wdog_err_d;
  logic [31:0]            stall_cnt_q, stall_cnt_d;
  logic [15:0]            flush_cnt_q, flush_cnt_d;

  logic [5:0]             stall_int;
  logic                   flush_int;
  logic                   ack_int;

  // Next-state and stage-control decode; the exception waits while MEM itself is stalled
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    new_pc_d  = new_pc_q;
    stall_int = STALL_NONE;
    flush_int = 1'b0;
    ack_int   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (stallreq_mem)     stall_int = STALL_MEM;
        else if (stallreq_ex) stall_int = STALL_EX;
        else if (stallreq_id) stall_int = STALL_ID;
        else if (stallreq_if) stall_int = STALL_IF;
        if (excp_valid && !stallreq_mem) begin
          state_d = ST_ACCEPT;
          vec_d   = excp_vector;
        end
      end
      ST_ACCEPT: begin
        stall_int = STALL_ALL;
        ack_int   = 1'b1;
        new_pc_d  = vec_q;
        state_d   = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush_int = 1'b1;
        state_d   = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Reset zeroes the pulse/hold outputs combinationally, without waiting for a clock
  assign stall     = rst ? stall_int : STALL_NONE;
  assign flush     = rst & flush_int;
  assign excp_ack  = rst & ack_int;
  assign new_pc    = new_pc_q;
  assign wdog_err  = wdog_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Watchdog and saturating counter next values
  always_comb begin
    wdog_cnt_d  = 16'd0;
    wdog_err_d  = wdog_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall != STALL_NONE) begin
      wdog_cnt_d = (wdog_cnt_q == WDOG_LIM16) ? wdog_cnt_q : wdog_cnt_q + 16'd1;
    end
    if (wdog_cnt_d == WDOG_LIM16) wdog_err_d = 1'b1;
    if (stall[0] && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // FSM state, latched exception vector and redirect PC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      vec_q    <= ZeroWord;
      new_pc_q <= ZeroWord;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      new_pc_q <= new_pc_d;
    end
  end

  // Watchdog counter, sticky error flag and performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_cnt_q  <= 16'd0;
      wdog_err_q  <= 1'b0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_err_q  <= wdog_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        excp_valid;
  logic [31:0] excp_vector;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        excp_ack;
  logic        wdog_err;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.WDOG_LIMIT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excp_valid   (excp_valid),
    .excp_vector  (excp_vector),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .excp_ack     (excp_ack),
    .wdog_err     (wdog_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_if  = 1'b0;
    stallreq_id  = 1'b0;
    stallreq_ex  = 1'b0;
    stallreq_mem = 1'b0;
    excp_valid   = 1'b0;
    excp_vector  = 32'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    stallreq_mem = 1'b1;
    #2;
    checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL reset_stall_comb got %b exp %b", stall, 6'b000000); end
    stallreq_mem = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    #1;
    checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL reset_stall got %b exp 000000", stall); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
    checks++; if (new_pc !== 32'h0) begin errors++; $display("FAIL reset_new_pc got %h exp 0", new_pc); end
    checks++; if (excp_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", excp_ack); end
    checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL reset_wdog got %b exp 0", wdog_err); end
  endtask

  task automatic test_priority();
    next_cycle();
    stallreq_if = 1'b1; #1;
    checks++; if (stall !== 6'b000011) begin errors++; $display("FAIL prio_if got %b exp 000011", stall); end
    stallreq_mem = 1'b1; #1;
    checks++; if (stall !== 6'b011111) begin errors++; $display("FAIL prio_mem got %b exp 011111", stall); end
    stallreq_if = 1'b0; stallreq_mem = 1'b0; #1;
    checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL prio_none got %b exp 000000", stall); end
  endtask

  task automatic test_id_ex();
    next_cycle();
    stallreq_id = 1'b1;
    stallreq_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (stall !== 6'b001111) begin errors++; $display("FAIL id_ex_stall cycle %0d got %b exp 001111", i, stall); end
      next_cycle();
    end
    stallreq_id = 1'b0;
    stallreq_ex = 1'b0;
    #1;
    checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL id_ex_stall_cnt got %0d exp 3", stall_cnt); end
    checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL id_ex_release got %b exp 000000", stall); end
  endtask

  task automatic test_exception();
    next_cycle();
    excp_valid  = 1'b1;
    excp_vector = 32'h0000_0380;
    #1;
    checks++; if (excp_ack !== 1'b0 || stall !== 6'b000000) begin errors++; $display("FAIL excp_cycle_n got ack=%b stall=%b exp ack=0 stall=000000", excp_ack, stall); end
    next_cycle();
    checks++; if (excp_ack !== 1'b1) begin errors++; $display("FAIL excp_ack got %b exp 1", excp_ack); end
    checks++; if (stall !== 6'b111111) begin errors++; $display("FAIL excp_accept_stall got %b exp 111111", stall); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL excp_accept_flush got %b exp 0", flush); end
    next_cycle();
    excp_valid  = 1'b0;
    stallreq_id = 1'b1;
    #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL excp_flush got %b exp 1", flush); end
    checks++; if (new_pc !== 32'h0000_0380) begin errors++; $display("FAIL excp_new_pc got %h exp 00000380", new_pc); end
    checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL excp_flush_stall got %b exp 000000", stall); end
    checks++; if (excp_ack !== 1'b0) begin errors++; $display("FAIL excp_flush_ack got %b exp 0", excp_ack); end
    next_cycle();
    stallreq_id = 1'b0;
    #1;
    checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL excp_flush_cnt got %0d exp 1", flush_cnt); end
    checks++; if (flush !== 1'b0 || new_pc !== 32'h0000_0380) begin errors++; $display("FAIL excp_after got flush=%b new_pc=%h exp 0/00000380", flush, new_pc); end
    checks++; if (stall_cnt !== 32'd4) begin errors++; $display("FAIL excp_stall_cnt got %0d exp 4", stall_cnt); end
  endtask

  task automatic test_excp_mem_stall();
    next_cycle();
    excp_valid   = 1'b1;
    excp_vector  = 32'h0000_0400;
    stallreq_mem = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (stall !== 6'b011111 || excp_ack !== 1'b0) begin errors++; $display("FAIL mem_wait cycle %0d got stall=%b ack=%b exp 011111/0", i, stall, excp_ack); end
      next_cycle();
    end
    stallreq_mem = 1'b0;
    #1;
    checks++; if (excp_ack !== 1'b0 || stall !== 6'b000000) begin errors++; $display("FAIL mem_drop got ack=%b stall=%b exp 0/000000", excp_ack, stall); end
    next_cycle();
    checks++; if (excp_ack !== 1'b1) begin errors++; $display("FAIL mem_late_ack got %b exp 1", excp_ack); end
    next_cycle();
    excp_valid = 1'b0;
    #1;
    checks++; if (flush !== 1'b1 || new_pc !== 32'h0000_0400) begin errors++; $display("FAIL mem_flush got flush=%b new_pc=%h exp 1/00000400", flush, new_pc); end
    next_cycle();
    checks++; if (flush_cnt !== 16'd2 || stall_cnt !== 32'd9) begin errors++; $display("FAIL mem_counters got flush=%0d stall=%0d exp 2/9", flush_cnt, stall_cnt); end
  endtask

  task automatic test_watchdog();
    next_cycle();
    stallreq_ex = 1'b1;
    for (int i = 0; i < 7; i++) next_cycle();
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL wdog_early got %b exp 0", wdog_err); end
    next_cycle();
    checks++; if (wdog_err !== 1'b1) begin errors++; $display("FAIL wdog_set got %b exp 1", wdog_err); end
    stallreq_ex = 1'b0;
    next_cycle();
    next_cycle();
    checks++; if (wdog_err !== 1'b1) begin errors++; $display("FAIL wdog_sticky got %b exp 1", wdog_err); end
    checks++; if (stall_cnt !== 32'd17) begin errors++; $display("FAIL wdog_stall_cnt got %0d exp 17", stall_cnt); end
  endtask

  task automatic test_reset_accept();
    next_cycle();
    excp_valid  = 1'b1;
    excp_vector = 32'h0000_0500;
    next_cycle();
    checks++; if (excp_ack !== 1'b1) begin errors++; $display("FAIL rst_acc_ack got %b exp 1", excp_ack); end
    #1;
    rst = 1'b0;
    excp_valid = 1'b0;
    #1;
    checks++; if (stall !== 6'b000000 || excp_ack !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL rst_acc_outputs got stall=%b ack=%b flush=%b exp 0", stall, excp_ack, flush); end
    checks++; if (new_pc !== 32'h0 || stall_cnt !== 32'd0 || flush_cnt !== 16'd0 || wdog_err !== 1'b0) begin errors++; $display("FAIL rst_acc_state got pc=%h sc=%0d fc=%0d wd=%b exp 0", new_pc, stall_cnt, flush_cnt, wdog_err); end
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      checks++; if (flush !== 1'b0 || excp_ack !== 1'b0) begin errors++; $display("FAIL rst_acc_no_flush cycle %0d got flush=%b ack=%b exp 0/0", i, flush, excp_ack); end
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_id_ex();
    test_exception();
    test_excp_mem_stall();
    test_watchdog();
    test_reset_accept();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
